// File: rtl/mmu_sequencer.sv
// mmu_sequencer: central job sequencer for the 2x2 TPU datapath.
// Counts host byte loads into the weight/input memory, pulses the PE accumulator
// clear, runs the feeder/array compute window, then steps the result byte selector.
module mmu_sequencer #(
  parameter int LOAD_WORDS  = 8,  // bytes per job (4 weights + 4 inputs)
  parameter int FEED_CYCLES = 5,  // compute window length, 1..8
  parameter int OUT_BYTES   = 8   // result bytes streamed to host, 1..8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic       abort,
  output logic       mem_we,
  output logic [2:0] mem_addr,
  output logic       clear,
  output logic       mmu_en,
  output logic [2:0] mmu_cycle,
  output logic [2:0] out_sel,
  output logic       out_valid,
  output logic       done,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    FEED  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Terminal values of the three counters, sized to the 3-bit count registers.
  localparam logic [2:0] LOAD_LAST = 3'(LOAD_WORDS - 1);
  localparam logic [2:0] FEED_LAST = 3'(FEED_CYCLES - 1);
  localparam logic [2:0] OUT_LAST  = 3'(OUT_BYTES - 1);
  // out_sel value one step before the last byte; done is registered, so it is
  // raised on the transition into the final byte.
  localparam logic [2:0] OUT_PREV  = 3'(OUT_BYTES - 2);

  state_t     state;
  logic [2:0] load_cnt;
  logic       clear_r;
  logic       mmu_en_r;
  logic [2:0] mmu_cycle_r;
  logic [2:0] out_sel_r;
  logic       out_valid_r;
  logic       done_r;
  logic       busy_r;

  // Memory writes are only accepted while collecting a job; an abort or reset in
  // the same cycle suppresses the write so a cancelled job never touches memory.
  assign mem_we   = load_en & ~abort & ~rst & ((state == IDLE) || (state == LOAD));
  assign mem_addr = load_cnt;

  assign clear     = clear_r;
  assign mmu_en    = mmu_en_r;
  assign mmu_cycle = mmu_cycle_r;
  assign out_sel   = out_sel_r;
  assign out_valid = out_valid_r;
  assign done      = done_r;
  assign busy      = busy_r;

  // Job FSM: state, counters and all status outputs update together so every
  // output is a flop that reflects the state being entered.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state       <= IDLE;
      load_cnt    <= 3'd0;
      clear_r     <= 1'b0;
      mmu_en_r    <= 1'b0;
      mmu_cycle_r <= 3'd0;
      out_sel_r   <= 3'd0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_en) begin
            busy_r <= 1'b1;
            if (LOAD_WORDS == 1) begin
              state    <= CLEAR;
              load_cnt <= 3'd0;
              clear_r  <= 1'b1;
            end else begin
              state    <= LOAD;
              load_cnt <= 3'd1;
            end
          end
        end

        LOAD: begin
          // load_en low is a pause: count and state simply hold.
          if (load_en) begin
            if (load_cnt == LOAD_LAST) begin
              state    <= CLEAR;
              load_cnt <= 3'd0;
              clear_r  <= 1'b1;
            end else begin
              load_cnt <= load_cnt + 3'd1;
            end
          end
        end

        CLEAR: begin
          state       <= FEED;
          clear_r     <= 1'b0;
          mmu_en_r    <= 1'b1;
          mmu_cycle_r <= 3'd0;
        end

        FEED: begin
          if (mmu_cycle_r == FEED_LAST) begin
            state       <= DRAIN;
            mmu_en_r    <= 1'b0;
            mmu_cycle_r <= 3'd0;
            out_valid_r <= 1'b1;
            out_sel_r   <= 3'd0;
            done_r      <= (OUT_BYTES == 1);
          end else begin
            mmu_cycle_r <= mmu_cycle_r + 3'd1;
          end
        end

        DRAIN: begin
          if (out_sel_r == OUT_LAST) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            out_sel_r   <= 3'd0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            out_sel_r <= out_sel_r + 3'd1;
            done_r    <= (out_sel_r == OUT_PREV);
          end
        end

        default: begin
          state       <= IDLE;
          load_cnt    <= 3'd0;
          clear_r     <= 1'b0;
          mmu_en_r    <= 1'b0;
          mmu_cycle_r <= 3'd0;
          out_sel_r   <= 3'd0;
          out_valid_r <= 1'b0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed bench for mmu_sequencer: every cycle the full output vector is
// compared against a hand-built expected vector.
module tb_mmu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_en = 1'b0;
  logic       abort = 1'b0;
  logic       mem_we;
  logic [2:0] mem_addr;
  logic       clear;
  logic       mmu_en;
  logic [2:0] mmu_cycle;
  logic [2:0] out_sel;
  logic       out_valid;
  logic       done;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  mmu_sequencer #(
    .LOAD_WORDS (8),
    .FEED_CYCLES(5),
    .OUT_BYTES  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .abort    (abort),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .clear    (clear),
    .mmu_en   (mmu_en),
    .mmu_cycle(mmu_cycle),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // {we, addr[3], clear, en, cycle[3], sel[3], valid, done, busy}
  logic [14:0] obs;
  assign obs = {mem_we, mem_addr, clear, mmu_en, mmu_cycle, out_sel, out_valid, done, busy};

  function automatic logic [14:0] ev(input int we, input int addr, input int clr,
                                     input int en, input int cyc, input int sel,
                                     input int vld, input int dn, input int bsy);
    ev = {1'(we), 3'(addr), 1'(clr), 1'(en), 3'(cyc), 3'(sel), 1'(vld), 1'(dn), 1'(bsy)};
  endfunction

  task automatic check(input string tag, input logic [14:0] act, input logic [14:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (we addr clr en cyc sel vld done busy)",
                  tag, act, exp);
  endtask

  // Drive one cycle's inputs after the falling edge, then settle before sampling.
  task automatic cyc(input logic le, input logic ab, input logic r);
    @(negedge clk);
    load_en = le;
    abort   = ab;
    rst     = r;
    #1;
  endtask

  localparam logic [14:0] ZERO = 15'd0;

  task automatic run_job(input string nm, input bit stray, input bit gap,
                         input int abort_at, input int rst_at, input bit tail);
    for (int i = 0; i < 8; i++) begin
      if (gap && i > 0) begin
        cyc(1'b0, 1'b0, 1'b0);
        check($sformatf("%s gap%0d", nm, i), obs, ev(0, i, 0, 0, 0, 0, 0, 0, 1));
      end
      cyc(1'b1, 1'b0, 1'b0);
      check($sformatf("%s load%0d", nm, i), obs, ev(1, i, 0, 0, 0, 0, 0, 0, (i > 0)));
    end
    cyc(stray, 1'b0, 1'b0);
    check($sformatf("%s clear", nm), obs, ev(0, 0, 1, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 5; k++) begin
      if (k == abort_at) begin
        cyc(stray, 1'b1, 1'b0);
        check($sformatf("%s abort_cyc", nm), obs, ev(0, 0, 0, 1, k, 0, 0, 0, 1));
        cyc(1'b0, 1'b0, 1'b0);
        check($sformatf("%s post_abort", nm), obs, ZERO);
        return;
      end
      cyc(stray, 1'b0, 1'b0);
      check($sformatf("%s feed%0d", nm, k), obs, ev(0, 0, 0, 1, k, 0, 0, 0, 1));
    end
    for (int k = 0; k < 8; k++) begin
      if (k == rst_at) begin
        cyc(stray, 1'b0, 1'b1);
        check($sformatf("%s rst_cyc", nm), obs, ev(0, 0, 0, 0, 0, k, 1, 0, 1));
        cyc(1'b0, 1'b0, 1'b0);
        check($sformatf("%s post_rst", nm), obs, ZERO);
        return;
      end
      cyc(stray, 1'b0, 1'b0);
      check($sformatf("%s drain%0d", nm, k), obs, ev(0, 0, 0, 0, 0, k, 1, (k == 7), 1));
    end
    if (tail) begin
      cyc(1'b0, 1'b0, 1'b0);
      check($sformatf("%s idle", nm), obs, ZERO);
    end
  endtask

  initial begin
    // 1: reset held two cycles with load_en high
    load_en = 1'b1;
    rst     = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    check("rst_we", {14'd0, mem_we}, ZERO);
    cyc(1'b1, 1'b0, 1'b1);
    check("rst_all", obs, ZERO);
    cyc(1'b0, 1'b0, 1'b0);
    check("rst_release", obs, ZERO);

    // 2: nominal job
    run_job("nom", 1'b0, 1'b0, -1, -1, 1'b1);

    // 3: gapped loads
    run_job("gap", 1'b0, 1'b1, -1, -1, 1'b1);

    // 4: stray load_en through clear/feed/drain
    run_job("stray", 1'b1, 1'b0, -1, -1, 1'b1);

    // abort during LOAD with load_en high: no write in the abort cycle
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      check($sformatf("ldab load%0d", i), obs, ev(1, i, 0, 0, 0, 0, 0, 0, (i > 0)));
    end
    cyc(1'b1, 1'b1, 1'b0);
    check("ldab abort_cyc", obs, ev(0, 3, 0, 0, 0, 0, 0, 0, 1));
    cyc(1'b0, 1'b0, 1'b0);
    check("ldab post_abort", obs, ZERO);

    // 5: abort at FEED mmu_cycle=2, then a clean job from addr 0
    run_job("abf", 1'b0, 1'b0, 2, -1, 1'b0);
    run_job("after_abort", 1'b0, 1'b0, -1, -1, 1'b1);

    // 6: rst at DRAIN out_sel=3, then back-to-back jobs
    run_job("rstd", 1'b0, 1'b0, -1, 3, 1'b0);
    run_job("b2b_a", 1'b0, 1'b0, -1, -1, 1'b0);
    run_job("b2b_b", 1'b0, 1'b0, -1, -1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
